// File: rtl/ddr_frame_cmd_sched_if.sv
// ddr_frame_cmd_sched_if: command-port, request and status bundle of the frame command scheduler
interface ddr_frame_cmd_sched_if #(
    parameter int CH_NUM = 2
);
    logic [CH_NUM-1:0] wr_req;
    logic [CH_NUM-1:0] rd_req;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_cmd;
    logic [7:0]        cmd_bl;
    logic [27:0]       cmd_addr;
    logic [1:0]        cmd_ch;
    logic              burst_done;
    logic [CH_NUM-1:0] rd_start;
    logic [CH_NUM-1:0] frame_done;

    modport master (
        input  wr_req, rd_req, cmd_ready, burst_done,
        output cmd_valid, cmd_cmd, cmd_bl, cmd_addr, cmd_ch, rd_start, frame_done
    );

    modport slave (
        output wr_req, rd_req, cmd_ready, burst_done,
        input  cmd_valid, cmd_cmd, cmd_bl, cmd_addr, cmd_ch, rd_start, frame_done
    );
endinterface

// File: rtl/ddr_frame_cmd_sched.sv
// ddr_frame_cmd_sched: round-robin DDR3 command scheduler with per-channel frame buffering
module ddr_frame_cmd_sched #(
    parameter int CH_NUM      = 2,
    parameter int BURST_LEN   = 64,
    parameter int ADDR_STEP   = 512,
    parameter int FRAME_WORDS = 393216,
    parameter int FRAME_BUF   = 3,
    parameter int BASE_ADDR   = 0,
    parameter int CH_STRIDE   = FRAME_BUF * FRAME_WORDS
) (
    input  logic                   ui_clk,
    input  logic                   rst_n,
    ddr_frame_cmd_sched_if.master  bus
);
    localparam int NR = 2 * CH_NUM;
    localparam int RW = $clog2(NR);
    localparam logic [27:0] FE   = 28'(FRAME_WORDS - ADDR_STEP);
    localparam logic [27:0] STEP = 28'(ADDR_STEP);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [RW-1:0]     r_ptr;
    logic [RW-1:0]     r_gnt;
    logic [2:0]        r_cmd;
    logic [1:0]        r_ch;
    logic [27:0]       r_addr;
    logic [CH_NUM-1:0] r_rd_start;
    logic [CH_NUM-1:0] r_frame_done;
    logic [27:0]       r_off  [NR];
    logic [1:0]        r_wbuf [CH_NUM];
    logic [1:0]        r_rbuf [CH_NUM];
    logic [1:0]        r_last [CH_NUM];

    logic [NR-1:0]     w_req;
    logic [2*NR-1:0]   w_dbl;
    logic [NR-1:0]     w_rot;
    logic              w_any;
    logic [RW-1:0]     w_sel;
    logic [27:0]       w_off;
    logic [27:0]       w_goff;
    logic [1:0]        w_wb;
    logic [1:0]        w_rb;
    logic [1:0]        w_last;
    logic [1:0]        w_buf;
    logic [1:0]        w_gwb;
    logic [1:0]        w_grb;
    logic [1:0]        w_nb1;
    logic [1:0]        w_nb;
    logic [27:0]       w_addr;

    // Requester vector r=2*ch+{wr,rd}; reads stay masked until the channel owns a complete frame
    always_comb begin
        w_req = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            w_req[2*c]   = bus.wr_req[c];
            w_req[2*c+1] = bus.rd_req[c] & r_rd_start[c];
        end
    end

    // Round-robin pick: rotate so the pointer sits at bit 0, lowest set bit wins
    always_comb begin
        w_dbl = {w_req, w_req} >> r_ptr;
        w_rot = w_dbl[NR-1:0];
        w_any = 1'b0;
        w_sel = '0;
        for (int k = NR - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_any = 1'b1;
                w_sel = RW'((int'(r_ptr) + k) % NR);
            end
        end
    end

    // Address of the candidate grant and next write buffer of the granted channel
    always_comb begin
        w_off  = '0;
        w_goff = '0;
        w_wb   = '0;
        w_rb   = '0;
        w_last = '0;
        w_gwb  = '0;
        w_grb  = '0;
        for (int r = 0; r < NR; r++) begin
            if (r == int'(w_sel)) w_off = r_off[r];
            if (r == int'(r_gnt)) w_goff = r_off[r];
        end
        for (int c = 0; c < CH_NUM; c++) begin
            if (c == int'(w_sel >> 1)) begin
                w_wb   = r_wbuf[c];
                w_rb   = r_rbuf[c];
                w_last = r_last[c];
            end
            if (c == int'(r_ch)) begin
                w_gwb = r_wbuf[c];
                w_grb = r_rbuf[c];
            end
        end
        w_buf  = w_sel[0] ? ((w_off == '0) ? w_last : w_rb) : w_wb;
        w_addr = 28'(BASE_ADDR + int'(w_sel >> 1) * CH_STRIDE + int'(w_buf) * FRAME_WORDS + int'(w_off));
        w_nb1  = (int'(w_gwb) == FRAME_BUF - 1) ? 2'd0 : w_gwb + 2'd1;
        w_nb   = (FRAME_BUF == 3 && w_nb1 == w_grb) ? ((w_nb1 == 2'd2) ? 2'd0 : w_nb1 + 2'd1) : w_nb1;
    end

    // FSM state register
    always_ff @(posedge ui_clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // FSM next state: grant, handshake, then wait for the data phase to finish
    always_comb begin
        w_next = r_state;
        if (r_state == S_IDLE && w_any)                w_next = S_ISSUE;
        else if (r_state == S_ISSUE && bus.cmd_ready)  w_next = S_WAIT;
        else if (r_state == S_WAIT && bus.burst_done)  w_next = S_IDLE;
    end

    // Command latch at grant; offsets, pointer and buffer rotation on burst completion
    always_ff @(posedge ui_clk) begin
        if (!rst_n) begin
            r_ptr        <= '0;
            r_gnt        <= '0;
            r_cmd        <= '0;
            r_ch         <= '0;
            r_addr       <= '0;
            r_rd_start   <= '0;
            r_frame_done <= '0;
            for (int r = 0; r < NR; r++) r_off[r] <= '0;
            for (int c = 0; c < CH_NUM; c++) begin
                r_wbuf[c] <= '0;
                r_rbuf[c] <= '0;
                r_last[c] <= '0;
            end
        end else begin
            r_frame_done <= '0;
            if (r_state == S_IDLE && w_any) begin
                r_gnt  <= w_sel;
                r_cmd  <= {2'b00, w_sel[0]};
                r_ch   <= 2'(w_sel >> 1);
                r_addr <= w_addr;
                for (int c = 0; c < CH_NUM; c++)
                    if (w_sel[0] && w_off == '0 && c == int'(w_sel >> 1)) r_rbuf[c] <= w_last;
            end
            if (r_state == S_WAIT && bus.burst_done) begin
                r_ptr <= (int'(r_gnt) == NR - 1) ? '0 : r_gnt + 1'b1;
                for (int r = 0; r < NR; r++)
                    if (r == int'(r_gnt)) r_off[r] <= (r_off[r] == FE) ? '0 : r_off[r] + STEP;
                for (int c = 0; c < CH_NUM; c++) begin
                    if (!r_gnt[0] && w_goff == FE && c == int'(r_ch)) begin
                        r_frame_done[c] <= 1'b1;
                        r_rd_start[c]   <= 1'b1;
                        r_last[c]       <= r_wbuf[c];
                        r_wbuf[c]       <= w_nb;
                    end
                end
            end
        end
    end

    // Output drive: valid only while issuing, command fields from the grant latch
    always_comb begin
        bus.cmd_valid  = (r_state == S_ISSUE);
        bus.cmd_cmd    = r_cmd;
        bus.cmd_bl     = 8'(BURST_LEN);
        bus.cmd_addr   = r_addr;
        bus.cmd_ch     = r_ch;
        bus.rd_start   = r_rd_start;
        bus.frame_done = r_frame_done;
    end
endmodule
